conv_frame_sequencer: RTL and testbench

- Sequences one image frame through the 5x5 convolution line buffer: holds the K*K coefficient bank, streams pixels into the buffer, and gates its enable.
- Tracks row/column position and passes on only buffer outputs that correspond to fully populated (valid, unpadded) windows.
- Provides start/done control and ready/valid handshakes on both the pixel and result streams.
- Sits between the pixel source and the convolution buffer instance.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_coeff_bank.sv | 59 +++++
 rtl/conv_frame_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution frame sequencer: FSM encoding,
// default datapath widths and the number of valid windows per frame.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DEF_K  = 5;
    localparam int DEF_DW = 12;
    localparam int DEF_CW = 8;

    // Number of fully populated (unpadded) KxK windows in an img_w x img_h frame.
    function automatic int result_count(input int img_w, input int img_h, input int k);
        return (img_w - k + 1) * (img_h - k + 1);
    endfunction

endpackage

// File: rtl/conv_coeff_bank.sv
// K*K coefficient register file with a serial write port, a wrapping write
// index and a flattened read-out bus (slot i at bits [i*CW +: CW]).
module conv_coeff_bank import conv_pkg::*; #(
    parameter int K  = DEF_K,
    parameter int CW = DEF_CW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CW-1:0]     wr_data,
    input  logic              idx_clr,
    output logic [K*K*CW-1:0] bank
);

    localparam int N     = K * K;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic [CW-1:0]    mem_q [N];
    logic [CW-1:0]    mem_d [N];
    logic [IDX_W-1:0] idx_q, idx_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        mem_d = mem_q;
        idx_d = idx_q;
        if (wr_en) begin
            mem_d[idx_q] = wr_data;
            idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        // A write coinciding with start lands at the old index, then the index restarts.
        if (idx_clr) begin
            idx_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
    // NOTE: the bank is a small flop array that must read as zero after reset, so it is reset
    //       element by element rather than left to power-up contents as a RAM would be.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
            idx_q <= '0;
        end else begin
            mem_q <= mem_d;
            idx_q <= idx_d;
        end
    end

    always_comb begin
        bank = '0;
        for (int i = 0; i < N; i++) begin
            bank[i*CW +: CW] = mem_q[i];
        end
    end

endmodule

// File: rtl/conv_frame_sequencer.sv
// Streams one frame through the external KxK convolution buffer, tracks the
// raster position and forwards only results of fully populated windows.
module conv_frame_sequencer import conv_pkg::*; #(
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 32,
    parameter int K        = DEF_K,
    parameter int DW       = DEF_DW,
    parameter int CW       = DEF_CW,
    parameter int PIPE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coeff_valid,
    input  logic [CW-1:0]     coeff_data,
    input  logic              start,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DW-1:0]     pix_data,
    output logic              buf_en,
    output logic [DW-1:0]     buf_d_in,
    output logic [K*K*CW-1:0] buf_coeff,
    input  logic [DW-1:0]     buf_d_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int ROW_W     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RES_TOTAL = result_count(IMG_W, IMG_H, K);
    localparam int RES_W     = $clog2(RES_TOTAL + 1);
    localparam int DRN_W     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_KM1  = ROW_W'(K - 1);
    localparam logic [COL_W-1:0] COL_KM1  = COL_W'(K - 1);
    localparam logic [RES_W-1:0] RES_LAST = RES_W'(RES_TOTAL - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic [RES_W-1:0] res_cnt_q, res_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic stall_ok;
    logic tag_in;
    logic tag_exit;
    logic capture;
    logic frame_start;

    assign frame_start = (state_q == S_IDLE) && start;

    conv_coeff_bank #(.K(K), .CW(CW)) u_coeff_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (coeff_valid && (state_q == S_IDLE)),
        .wr_data (coeff_data),
        .idx_clr (frame_start),
        .bank    (buf_coeff)
    );

    // The buffer only moves when its oldest result can be taken, so a pending
    // result is never overwritten.
    assign stall_ok = out_ready || !out_valid_q;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        drain_d   = drain_q;
        pix_ready = 1'b0;
        buf_en    = 1'b0;
        buf_d_in  = '0;
        tag_in    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    row_d   = '0;
                    col_d   = '0;
                    drain_d = '0;
                end
            end
            S_RUN: begin
                pix_ready = stall_ok;
                if (pix_valid && stall_ok) begin
                    buf_en   = 1'b1;
                    buf_d_in = pix_data;
                    tag_in   = (row_q >= ROW_KM1) && (col_q >= COL_KM1);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = (PIPE_LAT == 0) ? S_DONE : S_DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (stall_ok) begin
                    buf_en = 1'b1;
                    if (drain_q == DRN_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // Valid-window tags travel alongside the buffer contents; the tag leaving
    // the pipe on an enabled cycle belongs to the buf_d_out presented that cycle.
    generate
        if (PIPE_LAT > 0) begin : g_tag_pipe
            logic [PIPE_LAT-1:0] tag_q, tag_d;

            always_comb begin
                tag_d = tag_q;
                if (buf_en) begin
                    tag_d[0] = tag_in;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        tag_d[i] = tag_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    tag_q <= '0;
                end else begin
                    tag_q <= tag_d;
                end
            end

            assign tag_exit = tag_q[PIPE_LAT-1];
        end else begin : g_tag_bypass
            assign tag_exit = tag_in;
        end
    endgenerate

    assign capture = buf_en && tag_exit;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        res_cnt_d   = res_cnt_q;
        if (capture) begin
            out_valid_d = 1'b1;
            out_data_d  = buf_d_out;
            out_last_d  = (res_cnt_q == RES_LAST);
            res_cnt_d   = res_cnt_q + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (frame_start) begin
            res_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            drain_q     <= '0;
            res_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            drain_q     <= drain_d;
            res_cnt_q   <= res_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Scoreboard bench for conv_frame_sequencer on an 8x8 frame with a 1-deep
// behavioural buffer stand-in; expected results come from a raster-order model.
module tb_conv_frame_sequencer;

    localparam int IMG_W    = 8;
    localparam int IMG_H    = 8;
    localparam int K        = 5;
    localparam int DW       = 12;
    localparam int CW       = 8;
    localparam int PIPE_LAT = 1;
    localparam int NPIX     = IMG_W * IMG_H;
    localparam int NRES     = (IMG_W - K + 1) * (IMG_H - K + 1);
    localparam logic [DW-1:0] BUF_XOR = 12'hA5C;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              coeff_valid;
    logic [CW-1:0]     coeff_data;
    logic              start;
    logic              pix_valid;
    logic              pix_ready;
    logic [DW-1:0]     pix_data;
    logic              buf_en;
    logic [DW-1:0]     buf_d_in;
    logic [K*K*CW-1:0] buf_coeff;
    logic [DW-1:0]     buf_d_out;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    int   n_vec = 0;
    int   n_err = 0;
    int   got_cnt = 0;
    exp_t exp_q[$];
    logic [CW-1:0] cmodel [K*K];
    int   cidx = 0;

    always #5 clk = ~clk;

    conv_frame_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DW(DW), .CW(CW), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .coeff_valid(coeff_valid), .coeff_data(coeff_data),
        .start(start),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .buf_en(buf_en), .buf_d_in(buf_d_in), .buf_coeff(buf_coeff), .buf_d_out(buf_d_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    // Stand-in for the convolution buffer: one enabled cycle of latency, result = pixel ^ BUF_XOR.
    always @(posedge clk or negedge rst) begin
        if (!rst) buf_d_out <= '0;
        else if (buf_en) buf_d_out <= buf_d_in ^ BUF_XOR;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [K*K*CW-1:0] coeff_flat();
        logic [K*K*CW-1:0] f = '0;
        for (int i = 0; i < K*K; i++) f[i*CW +: CW] = cmodel[i];
        return f;
    endfunction

    task automatic clear_coeff_model();
        for (int i = 0; i < K*K; i++) cmodel[i] = '0;
        cidx = 0;
    endtask

    task automatic write_coeff(input logic [CW-1:0] v);
        coeff_valid = 1'b1;
        coeff_data  = v;
        @(posedge clk); #1;
        coeff_valid = 1'b0;
        cmodel[cidx] = v;
        cidx = (cidx + 1) % (K*K);
    endtask

    // Monitor: pops the scoreboard on every accepted result and checks hold stability.
    initial begin
        bit            hold_prev = 1'b0;
        logic [DW-1:0] held = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_prev = 1'b0;
                continue;
            end
            if (hold_prev) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, held);
            end
            hold_prev = out_valid && !out_ready;
            held      = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_result", out_data, ~out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                    got_cnt++;
                end
            end
        end
    end

    task automatic run_frame(input bit gaps, input bit bp, input bit abort, input bit start_coeff);
        logic [DW-1:0] pix [NPIX];
        int  nexp = 0;
        int  sent = 0;
        int  burst = 0;
        bit  burst_done = 1'b0;
        bit  xfer, seen_done = 1'b0, prev_en = 1'b0, prev_done = 1'b0;
        bit  finished = 1'b0;
        exp_t e;

        for (int i = 0; i < NPIX; i++) begin
            pix[i] = DW'($urandom_range(0, (1 << DW) - 1));
            if ((i / IMG_W) >= K - 1 && (i % IMG_W) >= K - 1) begin
                nexp++;
                e.data = pix[i] ^ BUF_XOR;
                e.last = (nexp == NRES);
                exp_q.push_back(e);
            end
        end
        got_cnt = 0;

        start = 1'b1;
        if (start_coeff) begin
            coeff_valid = 1'b1;
            coeff_data  = 8'h55;
            cmodel[cidx] = 8'h55;
        end
        cidx = 0;
        @(posedge clk); #1;
        start       = 1'b0;
        coeff_valid = 1'b0;
        pix_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_data    = pix[0];
        out_ready   = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (sent < NPIX) begin
                check("busy_run", busy, 1'b1);
                check("pix_ready_rule", pix_ready, out_ready || !out_valid);
                check("buf_en_xfer", buf_en, pix_valid && pix_ready);
                if (pix_valid && pix_ready) check("buf_d_in", buf_d_in, pix_data);
            end
            if (prev_done) check("done_pulse", done, 1'b0);
            if (done) begin
                check("done_after_flush", prev_en, 1'b1);
                check("done_all_sent", sent, NPIX);
                seen_done = 1'b1;
            end
            xfer      = pix_valid && pix_ready;
            prev_en   = buf_en;
            prev_done = done;

            if (abort && sent == 3 * IMG_W + 2) begin
                #2 rst = 1'b0;
                #1;
                check("rst_out_valid", out_valid, 1'b0);
                check("rst_buf_en", buf_en, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_pix_ready", pix_ready, 1'b0);
                check("rst_buf_coeff", buf_coeff, '0);
                repeat (3) begin
                    @(negedge clk);
                    check("rst_no_done", done, 1'b0);
                end
                @(posedge clk); #1;
                rst       = 1'b1;
                pix_valid = 1'b0;
                exp_q.delete();
                clear_coeff_model();
                finished = 1'b1;
                break;
            end
            if (seen_done && !done && exp_q.size() == 0) begin
                finished = 1'b1;
                break;
            end

            @(posedge clk); #1;
            if (xfer) sent++;
            start       = (sent == 20);
            coeff_valid = (sent == 21);
            coeff_data  = 8'hEE;
            pix_valid   = (sent < NPIX) && (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
            pix_data    = (sent < NPIX) ? pix[sent] : '0;
            if (bp && !seen_done) begin
                if (!burst_done && out_valid) begin
                    burst      = 5;
                    burst_done = 1'b1;
                end
                if (burst > 0) begin
                    out_ready = 1'b0;
                    burst--;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end else begin
                out_ready = 1'b1;
            end
        end
        start       = 1'b0;
        coeff_valid = 1'b0;
        pix_valid   = 1'b0;
        out_ready   = 1'b1;
        check("frame_timeout", finished, 1'b1);
        if (!abort) begin
            check("result_count", got_cnt, NRES);
            check("coeff_hold", buf_coeff, coeff_flat());
        end
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0;
        coeff_valid = 1'b0; coeff_data = '0; start = 1'b0;
        pix_valid = 1'b0; pix_data = '0; out_ready = 1'b1;
        clear_coeff_model();

        repeat (2) @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_buf_en", buf_en, 1'b0);
        check("reset_buf_coeff", buf_coeff, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_out_last", out_last, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < K*K; i++) write_coeff(CW'(i));
        check("coeff_load", buf_coeff, coeff_flat());
        check("coeff_slot24", buf_coeff[24*CW +: CW], 8'h18);
        write_coeff(8'hAA);
        check("coeff_wrap", buf_coeff[0 +: CW], 8'hAA);

        run_frame(1'b0, 1'b0, 1'b0, 1'b1);
        check("coeff_start_write", buf_coeff[1*CW +: CW], 8'h55);
        write_coeff(8'h77);
        check("coeff_idx_restart", buf_coeff[0 +: CW], 8'h77);

        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 1'b1, 1'b0, 1'b0);
        run_frame(1'b0, 1'b1, 1'b1, 1'b0);
        run_frame(1'b0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
